// File: rtl/drive_sequencer.sv
// drive_sequencer: PWM generation, H-bridge drive and line/junction/collision sequencing
// Ports: clk, rst_n (async active-low); dir_ctl line-follow command; col_detect collision level;
//        td_en/td_dir tone decision; shaft_l/shaft_r async encoder pulses;
//        hb_en_a/hb_en_b motor PWM enables; hb_in1..hb_in4 bridge directions;
//        state current state code; seq_done one-cycle completion pulse.
module drive_sequencer #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int PWM_HZ         = 80,
  parameter int FULL_PCT       = 80,
  parameter int VEER_PCT       = 20,
  parameter int TURN_PULSES    = 40,
  parameter int PASS_PULSES    = 16,
  parameter int BACKOFF_PULSES = 20,
  parameter int CNT_W          = 20,
  parameter int PULSE_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dir_ctl,
  input  logic       col_detect,
  input  logic       td_en,
  input  logic [1:0] td_dir,
  input  logic       shaft_l,
  input  logic       shaft_r,
  output logic       hb_en_a,
  output logic       hb_en_b,
  output logic       hb_in1,
  output logic       hb_in2,
  output logic       hb_in3,
  output logic       hb_in4,
  output logic [2:0] state,
  output logic       seq_done
);
  localparam int PERIOD  = CLK_HZ / PWM_HZ;
  localparam int FULL_P  = FULL_PCT > 80 ? 80 : FULL_PCT;
  localparam int VEER_P  = VEER_PCT > FULL_P ? FULL_P : VEER_PCT;
  localparam int SAT     = 2 ** PULSE_W - 1;
  localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] FULL_ON   = CNT_W'(PERIOD * FULL_P / 100);
  localparam logic [CNT_W-1:0] VEER_ON   = CNT_W'(PERIOD * VEER_P / 100);
  localparam logic [PULSE_W-1:0] T1 = PULSE_W'(TURN_PULSES > SAT ? SAT : TURN_PULSES);
  localparam logic [PULSE_W-1:0] T2 = PULSE_W'(2 * TURN_PULSES > SAT ? SAT : 2 * TURN_PULSES);
  localparam logic [PULSE_W-1:0] TP = PULSE_W'(PASS_PULSES > SAT ? SAT : PASS_PULSES);
  localparam logic [PULSE_W-1:0] TB = PULSE_W'(BACKOFF_PULSES > SAT ? SAT : BACKOFF_PULSES);
  localparam logic [2:0] M_STR = 3'd0, M_VL = 3'd1, M_PL = 3'd2, M_VR = 3'd3, M_PR = 3'd4;
  localparam logic [3:0] D_FWD = 4'b0110, D_PL = 4'b1010, D_PR = 4'b0101, D_REV = 4'b1001;
  typedef enum logic [2:0] {FWD = 3'd0, JUNCTION = 3'd1, TURN = 3'd2, PASS = 3'd3,
                            COLLISION = 3'd4, BACKOFF = 3'd5} state_t;
  state_t st, st_nx;
  logic [CNT_W-1:0] pwm_cnt;
  logic [PULSE_W-1:0] pulse_cnt, target, turn_tgt;
  logic [2:0] sync_l, sync_r, last_mode, dec_mode, mode;
  logic dec_valid, full, veer, edge_l, edge_r, sel_edge, counting, clr, done, finish, turn_left;
  logic en_a_nx, en_b_nx;
  logic [3:0] in_nx;
  assign state    = st;
  assign full     = pwm_cnt < FULL_ON;
  assign veer     = pwm_cnt < VEER_ON;
  assign edge_l   = sync_l[1] & ~sync_l[2];
  assign edge_r   = sync_r[1] & ~sync_r[2];
  assign target   = st == PASS ? TP : st == BACKOFF ? TB : turn_tgt;
  assign done     = pulse_cnt >= target;
  assign finish   = ((st == TURN || st == PASS) && !col_detect && done) || (st == BACKOFF && done);
  assign counting = st == TURN || st == PASS || st == BACKOFF;
  assign sel_edge = st == TURN && turn_left ? edge_r : edge_l;
  assign clr      = (st == JUNCTION && td_en) || (st == COLLISION && !col_detect);
  assign mode     = dec_valid ? dec_mode : last_mode;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= FWD;
    else st <= st_nx;
  always_comb begin
    st_nx = st;
    case (st)
      FWD:       st_nx = col_detect ? COLLISION : dir_ctl[3:2] == 2'b11 ? JUNCTION : FWD;
      JUNCTION:  st_nx = !td_en ? JUNCTION : td_dir == 2'b00 ? PASS : TURN;
      TURN,
      PASS:      st_nx = col_detect ? COLLISION : done ? FWD : st;
      COLLISION: st_nx = col_detect ? COLLISION : BACKOFF;
      BACKOFF:   st_nx = done ? FWD : BACKOFF;
      default:   st_nx = FWD;
    endcase
  end
  always_comb begin
    dec_valid = 1'b1;
    dec_mode  = M_STR;
    case (dir_ctl)
      4'b0000: dec_mode = M_STR;
      4'b0101: dec_mode = M_VL;
      4'b0111: dec_mode = M_PL;
      4'b1001: dec_mode = M_VR;
      4'b1011: dec_mode = M_PR;
      default: dec_valid = 1'b0;
    endcase
  end
  always_comb begin
    en_a_nx = 1'b0;
    en_b_nx = 1'b0;
    in_nx   = 4'b0000;
    case (st)
      FWD: begin
        en_a_nx = mode == M_VL ? veer : full;
        en_b_nx = mode == M_VR ? veer : full;
        in_nx   = mode == M_PL ? D_PL : mode == M_PR ? D_PR : D_FWD;
      end
      TURN: begin
        en_a_nx = full;
        en_b_nx = full;
        in_nx   = turn_left ? D_PL : D_PR;
      end
      PASS: begin
        en_a_nx = full;
        en_b_nx = full;
        in_nx   = D_FWD;
      end
      BACKOFF: begin
        en_a_nx = veer;
        en_b_nx = veer;
        in_nx   = D_REV;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {hb_en_a, hb_en_b, hb_in1, hb_in2, hb_in3, hb_in4} <= '0;
      seq_done <= 1'b0;
    end else begin
      {hb_en_a, hb_en_b, hb_in1, hb_in2, hb_in3, hb_in4} <= {en_a_nx, en_b_nx, in_nx};
      seq_done <= finish;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt == PERIOD_M1 ? '0 : pwm_cnt + CNT_W'(1);
  // two flops resynchronise, the third holds the previous level for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_l <= '0;
      sync_r <= '0;
    end else begin
      sync_l <= {sync_l[1:0], shaft_l};
      sync_r <= {sync_r[1:0], shaft_r};
    end
  // clear beats a coincident edge; counting saturates at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pulse_cnt <= '0;
    else if (clr) pulse_cnt <= '0;
    else if (counting && sel_edge && pulse_cnt != '1) pulse_cnt <= pulse_cnt + PULSE_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      turn_left <= 1'b0;
      turn_tgt  <= '0;
      last_mode <= M_STR;
    end else begin
      if (st == JUNCTION && td_en) begin
        turn_left <= td_dir == 2'b01;
        turn_tgt  <= td_dir == 2'b11 ? T2 : T1;
      end
      if (st == FWD && dec_valid) last_mode <= dec_mode;
    end
endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer: directed self-checking bench for drive_sequencer
module tb_drive_sequencer;
  logic clk = 1'b0, rst_n;
  logic [3:0] dir_ctl;
  logic col_detect, td_en, shaft_l, shaft_r;
  logic [1:0] td_dir;
  logic hb_en_a, hb_en_b, hb_in1, hb_in2, hb_in3, hb_in4, seq_done;
  logic [2:0] state;
  int n_chk = 0, n_fail = 0, n_done = 0, d0, a, b;
  drive_sequencer #(.CLK_HZ(1000), .PWM_HZ(10), .FULL_PCT(80), .VEER_PCT(20), .TURN_PULSES(4),
    .PASS_PULSES(3), .BACKOFF_PULSES(3), .CNT_W(20), .PULSE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .dir_ctl(dir_ctl), .col_detect(col_detect), .td_en(td_en),
    .td_dir(td_dir), .shaft_l(shaft_l), .shaft_r(shaft_r), .hb_en_a(hb_en_a), .hb_en_b(hb_en_b),
    .hb_in1(hb_in1), .hb_in2(hb_in2), .hb_in3(hb_in3), .hb_in4(hb_in4), .state(state),
    .seq_done(seq_done));
  always #5 clk = ~clk;
  always @(posedge clk) if (seq_done) n_done++;
  wire [3:0] hb = {hb_in1, hb_in2, hb_in3, hb_in4};
  wire [5:0] all_hb = {hb_en_a, hb_en_b, hb};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_l(input int n);
    repeat (n) begin shaft_l = 1'b1; tick(2); shaft_l = 1'b0; tick(2); end
  endtask
  task automatic pulse_r(input int n);
    repeat (n) begin shaft_r = 1'b1; tick(2); shaft_r = 1'b0; tick(2); end
  endtask
  task automatic measure();
    a = 0;
    b = 0;
    repeat (100) begin @(negedge clk); a += int'(hb_en_a); b += int'(hb_en_b); end
  endtask
  task automatic enter(input logic [1:0] d);
    dir_ctl = 4'b1100;
    tick(1);
    td_dir = d;
    td_en  = 1'b1;
    tick(1);
    td_en  = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; dir_ctl = 4'b0000; col_detect = 1'b0; td_en = 1'b0; td_dir = 2'b00;
    shaft_l = 1'b0; shaft_r = 1'b0;
    tick(2);
    check("rst_state", state, 0);
    check("rst_hb", all_hb, 0);
    check("rst_done", seq_done, 0);
    rst_n = 1'b1;
    tick(3);
    measure();
    check("fwd_duty_a", a, 80);
    check("fwd_duty_b", b, 80);
    check("fwd_dir", hb, 4'b0110);
    dir_ctl = 4'b0101;
    tick(3);
    measure();
    check("veer_l_duty_a", a, 20);
    check("veer_l_duty_b", b, 80);
    check("veer_l_dir", hb, 4'b0110);
    dir_ctl = 4'b1011;
    tick(3);
    check("pivot_r_dir", hb, 4'b0101);
    dir_ctl = 4'b0001;
    tick(3);
    check("hold_dir", hb, 4'b0101);
    check("hold_state", state, 0);
    dir_ctl = 4'b1100;
    tick(1);
    check("junc_state", state, 1);
    tick(1);
    check("junc_coast", all_hb, 0);
    td_dir = 2'b01; td_en = 1'b1;
    tick(1);
    td_en = 1'b0; dir_ctl = 4'b0000;
    check("turn_l_state", state, 2);
    tick(1);
    check("turn_l_dir", hb, 4'b1010);
    d0 = n_done;
    pulse_l(2);
    pulse_r(3);
    check("turn_l_3", state, 2);
    check("turn_l_nodone", n_done - d0, 0);
    pulse_r(1);
    check("turn_l_end", state, 0);
    tick(3);
    check("turn_l_done", n_done - d0, 1);
    check("turn_l_stay", state, 0);
    enter(2'b11);
    dir_ctl = 4'b0000;
    check("back_state", state, 2);
    tick(1);
    check("back_dir", hb, 4'b0101);
    d0 = n_done;
    pulse_r(3);
    pulse_l(7);
    check("back_7", state, 2);
    pulse_l(1);
    check("back_end", state, 0);
    tick(3);
    check("back_done", n_done - d0, 1);
    enter(2'b01);
    dir_ctl = 4'b0000;
    pulse_r(1);
    check("col_pre", state, 2);
    shaft_r = 1'b1; col_detect = 1'b1;
    tick(1);
    check("col_enter", state, 4);
    tick(1);
    check("col_coast", all_hb, 0);
    shaft_r = 1'b0;
    tick(2);
    check("col_hold", state, 4);
    d0 = n_done;
    col_detect = 1'b0;
    tick(1);
    check("boff_state", state, 5);
    tick(1);
    check("boff_dir", hb, 4'b1001);
    pulse_l(1);
    col_detect = 1'b1;
    tick(2);
    check("boff_ign_col", state, 5);
    col_detect = 1'b0;
    pulse_l(1);
    check("boff_2", state, 5);
    pulse_l(1);
    check("boff_end", state, 0);
    tick(3);
    check("boff_done", n_done - d0, 1);
    enter(2'b00);
    check("pass_state", state, 3);
    tick(1);
    check("pass_dir", hb, 4'b0110);
    pulse_l(1);
    check("pass_ign_dir", state, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_hb", all_hb, 0);
    check("arst_cnt", dut.pulse_cnt, 0);
    dir_ctl = 4'b0000;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_state", state, 0);
    check("post_rst_cnt", dut.pulse_cnt, 0);
    enter(2'b00);
    check("pass2_state", state, 3);
    d0 = n_done;
    pulse_l(2);
    check("pass2_2", state, 3);
    dir_ctl = 4'b0000;
    pulse_l(1);
    check("pass2_end", state, 0);
    tick(3);
    check("pass2_done", n_done - d0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
